// File: rtl/move_queue_unpacker.sv
// move_queue_unpacker
//   Unpacks 4-bit move codes from packed batches into a FIFO. Moves are issued one at a time
//   to the stepper driver over a start/done handshake. After each completed move the block
//   waits a fixed settle time so the mechanism and colour sensors can stabilise.
//
// Ports
//   clock_25mhz  : system clock
//   reset        : asynchronous active-low reset
//   batch_valid  : a batch is offered on batch
//   batch        : packed moves, move k = batch[4k+3:4k], k = 0 issued first
//   batch_ready  : a batch can be accepted this cycle
//   flush        : synchronous discard of queued and still-unpacking moves
//   move_done    : one-cycle pulse from the driver when the current move finishes
//   next_move    : move code presented to the driver
//   move_start   : one-cycle pulse to start next_move
//   busy         : a move is in flight or settling
//   queue_empty  : FIFO holds no moves
//   count        : FIFO occupancy, 0..DEPTH
//   bad_code     : sticky flag, set when code 1, 14 or 15 is unpacked
module move_queue_unpacker #(
  parameter int unsigned MOVES_PER_BATCH = 50,
  parameter int unsigned DEPTH           = 64,
  parameter int unsigned SETTLE_CYCLES   = 250000
) (
  input  logic                         clock_25mhz,
  input  logic                         reset,
  input  logic                         batch_valid,
  input  logic [4*MOVES_PER_BATCH-1:0] batch,
  output logic                         batch_ready,
  input  logic                         flush,
  input  logic                         move_done,
  output logic [3:0]                   next_move,
  output logic                         move_start,
  output logic                         busy,
  output logic                         queue_empty,
  output logic [6:0]                   count,
  output logic                         bad_code
);

  localparam int unsigned BatchW = 4 * MOVES_PER_BATCH;
  localparam int unsigned PtrW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned IdxW   = (MOVES_PER_BATCH > 1) ? $clog2(MOVES_PER_BATCH) : 1;
  localparam int unsigned SetW   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;

  localparam logic [IdxW-1:0] LastIdx    = IdxW'(MOVES_PER_BATCH - 1);
  localparam logic [SetW-1:0] SettleLoad = SetW'(SETTLE_CYCLES);

  localparam logic U_IDLE = 1'b0;
  localparam logic U_RUN  = 1'b1;

  localparam logic [1:0] I_IDLE   = 2'd0;
  localparam logic [1:0] I_ISSUE  = 2'd1;
  localparam logic [1:0] I_WAIT   = 2'd2;
  localparam logic [1:0] I_SETTLE = 2'd3;

  logic              ustate_q, ustate_d;
  logic [BatchW-1:0] shift_q, shift_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              started_q;
  logic              bad_q, bad_d;

  logic [3:0]        mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [6:0]        count_q, count_d;

  logic [1:0]        istate_q, istate_d;
  logic [SetW-1:0]   settle_q, settle_d;
  logic [3:0]        next_move_q, next_move_d;
  logic              move_start_q;

  logic [3:0] slot;
  logic       slot_valid, slot_bad, has_space, accept, wr_en, rd_en;

  // The slot under examination is always the low nibble of the shift register.
  assign slot       = shift_q[3:0];
  assign slot_valid = (slot >= 4'd2) && (slot <= 4'd13);
  assign slot_bad   = (slot == 4'd1) || (slot >= 4'd14);
  assign has_space  = (32'(count_q) + MOVES_PER_BATCH) <= DEPTH;

  // started_q keeps batch_ready low for the first cycle after reset release.
  assign batch_ready = started_q && (ustate_q == U_IDLE) && has_space && !flush;
  assign accept      = batch_valid && batch_ready;
  assign wr_en       = (ustate_q == U_RUN) && slot_valid && !flush;
  assign rd_en       = (istate_q == I_IDLE) && (count_q != 7'd0) && !flush;

  assign next_move   = next_move_q;
  assign move_start  = move_start_q;
  assign busy        = (istate_q != I_IDLE);
  assign queue_empty = (count_q == 7'd0);
  assign count       = count_q;
  assign bad_code    = bad_q;

  // Unpack FSM: one slot per clock, code 0 terminates the batch early.
  always_comb begin
    ustate_d = ustate_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
    bad_d    = bad_q;
    if (flush) begin
      ustate_d = U_IDLE;
    end else if (ustate_q == U_IDLE) begin
      if (accept) begin
        shift_d  = batch;
        idx_d    = '0;
        ustate_d = U_RUN;
      end
    end else begin
      shift_d = shift_q >> 4;
      idx_d   = idx_q + 1'b1;
      if (slot_bad) bad_d = 1'b1;
      if ((slot == 4'd0) || (idx_q == LastIdx)) ustate_d = U_IDLE;
    end
  end

  // FIFO pointers and occupancy; flush empties the queue outright.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = 7'd0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count_d = count_q + 7'd1;
        2'b01:   count_d = count_q - 7'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // Issue FSM. A move already handed to the driver always runs to completion, even on flush.
  always_comb begin
    istate_d    = istate_q;
    settle_d    = settle_q;
    next_move_d = next_move_q;
    case (istate_q)
      I_IDLE: begin
        if (rd_en) begin
          next_move_d = mem_q[rd_ptr_q];
          istate_d    = I_ISSUE;
        end
      end
      I_ISSUE: istate_d = I_WAIT;
      I_WAIT: begin
        if (move_done) begin
          if (SETTLE_CYCLES == 0) begin
            istate_d = I_IDLE;
          end else begin
            settle_d = SettleLoad;
            istate_d = I_SETTLE;
          end
        end
      end
      I_SETTLE: begin
        if (settle_q <= SetW'(1)) begin
          settle_d = '0;
          istate_d = I_IDLE;
        end else begin
          settle_d = settle_q - 1'b1;
        end
      end
      default: istate_d = I_IDLE;
    endcase
  end

  always_ff @(posedge clock_25mhz) begin
    if (wr_en) mem_q[wr_ptr_q] <= slot;
  end

  always_ff @(posedge clock_25mhz or negedge reset) begin
    if (!reset) begin
      ustate_q     <= U_IDLE;
      shift_q      <= '0;
      idx_q        <= '0;
      started_q    <= 1'b0;
      bad_q        <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= 7'd0;
      istate_q     <= I_IDLE;
      settle_q     <= '0;
      next_move_q  <= 4'd0;
      move_start_q <= 1'b0;
    end else begin
      ustate_q     <= ustate_d;
      shift_q      <= shift_d;
      idx_q        <= idx_d;
      started_q    <= 1'b1;
      bad_q        <= bad_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      istate_q     <= istate_d;
      settle_q     <= settle_d;
      next_move_q  <= next_move_d;
      // Registered pulse: high for the single cycle following I_ISSUE.
      move_start_q <= (istate_q == I_ISSUE);
    end
  end

endmodule

// File: tb/tb_move_queue_unpacker.sv
module tb_move_queue_unpacker;

  localparam int MPB    = 50;
  localparam int DEPTH  = 64;
  localparam int SETTLE = 8;

  logic             clock_25mhz = 1'b0;
  logic             reset       = 1'b0;
  logic             batch_valid = 1'b0;
  logic [4*MPB-1:0] batch       = '0;
  logic             flush       = 1'b0;
  logic             move_done   = 1'b0;
  logic             batch_ready, move_start, busy, queue_empty, bad_code;
  logic [3:0]       next_move;
  logic [6:0]       count;

  move_queue_unpacker #(
    .MOVES_PER_BATCH(MPB),
    .DEPTH          (DEPTH),
    .SETTLE_CYCLES  (SETTLE)
  ) dut (
    .clock_25mhz(clock_25mhz),
    .reset      (reset),
    .batch_valid(batch_valid),
    .batch      (batch),
    .batch_ready(batch_ready),
    .flush      (flush),
    .move_done  (move_done),
    .next_move  (next_move),
    .move_start (move_start),
    .busy       (busy),
    .queue_empty(queue_empty),
    .count      (count),
    .bad_code   (bad_code)
  );

  always #5 clock_25mhz = ~clock_25mhz;

  int cyc = 0;
  always @(posedge clock_25mhz) cyc <= cyc + 1;

  int         n_cmp  = 0;
  int         n_fail = 0;
  logic [3:0] exp_q[$];
  bit         exp_bad = 1'b0;

  int         n_starts        = 0;
  int         first_start_cyc = -1;
  int         last_start_cyc  = -1;
  int         accept_cyc      = 0;
  bit         check_spacing   = 1'b0;
  int         exp_spacing     = 0;
  int         max_count       = 0;
  bit         prev_start      = 1'b0;
  bit         hold            = 1'b0;
  logic [3:0] last_issued     = 4'd0;
  int         c_now           = 0;

  int done_lat  = 20;
  bit rand_lat  = 1'b0;
  bit auto_done = 1'b1;
  int drv_lat   = 0;

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clock_25mhz);
  endtask

  // Reference model: the whole batch is interpreted at once from the code rules.
  task automatic model_batch(input logic [4*MPB-1:0] b);
    for (int k = 0; k < MPB; k++) begin
      logic [3:0] c;
      c = b[4*k +: 4];
      if (c == 4'd0) break;
      if (c == 4'd1 || c == 4'd14 || c == 4'd15) exp_bad = 1'b1;
      else exp_q.push_back(c);
    end
  endtask

  // Monitor / scoreboard: pops an expected move for every move_start it sees.
  always @(negedge clock_25mhz) begin
    if (reset) begin
      c_now = int'(count);
      check("count_le_depth", (c_now <= DEPTH) ? 1 : 0, 1);
      check("empty_vs_count", int'(queue_empty), (c_now == 0) ? 1 : 0);
      if (c_now > max_count) max_count = c_now;
      if (batch_ready) check("ready_space", (DEPTH - c_now >= MPB) ? 1 : 0, 1);
      if (move_start) begin
        check("start_width", int'(prev_start), 0);
        n_starts++;
        if (first_start_cyc < 0) first_start_cyc = cyc;
        if (check_spacing && last_start_cyc >= 0)
          check("start_spacing", cyc - last_start_cyc, exp_spacing);
        last_start_cyc = cyc;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_start: next_move=%0d, expected no start (cycle %0d)",
                   next_move, cyc);
        end else begin
          last_issued = exp_q.pop_front();
          check("move_order", int'(next_move), int'(last_issued));
        end
        hold = 1'b1;
      end else if (hold) begin
        if (!busy) hold = 1'b0;
        else check("next_move_hold", int'(next_move), int'(last_issued));
      end
      prev_start = move_start;
    end else begin
      prev_start = 1'b0;
      hold       = 1'b0;
    end
  end

  // Driver model: answers each move_start with a move_done pulse after a latency.
  initial forever begin
    @(negedge clock_25mhz);
    if (reset && move_start && auto_done) begin
      drv_lat = rand_lat ? int'($urandom_range(2, 6)) : done_lat;
      repeat (drv_lat - 1) @(negedge clock_25mhz);
      move_done = 1'b1;
      @(negedge clock_25mhz);
      move_done = 1'b0;
    end
  end

  task automatic send_batch(input logic [4*MPB-1:0] b);
    int t = 0;
    while (!batch_ready && t < 5000) begin
      tick();
      t++;
    end
    if (!batch_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: batch_ready=0 after %0d cycles, required 1", t);
      return;
    end
    batch_valid = 1'b1;
    batch       = b;
    model_batch(b);
    tick();
    accept_cyc  = cyc;
    batch_valid = 1'b0;
  endtask

  function automatic bit is_idle();
    return (exp_q.size() == 0) && !busy && queue_empty && batch_ready;
  endfunction

  task automatic wait_idle(input string name);
    int t = 0;
    while (!is_idle() && t < 8000) begin
      tick();
      t++;
    end
    n_cmp++;
    if (t >= 8000) begin
      n_fail++;
      $display("FAIL %s: not idle after %0d cycles (model=%0d busy=%0b count=%0d), required idle",
               name, t, exp_q.size(), busy, count);
    end
  endtask

  task automatic wait_start(input int s0);
    int t = 0;
    while (n_starts == s0 && t < 200) begin
      tick();
      t++;
    end
    check("start_seen", (n_starts > s0) ? 1 : 0, 1);
  endtask

  // Called with reset low; checks reset values, then releases reset.
  task automatic reset_release(input string tag);
    #1;
    check({tag, "_next_move"}, int'(next_move), 0);
    check({tag, "_move_start"}, int'(move_start), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_queue_empty"}, int'(queue_empty), 1);
    check({tag, "_count"}, int'(count), 0);
    check({tag, "_bad_code"}, int'(bad_code), 0);
    check({tag, "_batch_ready"}, int'(batch_ready), 0);
    repeat (3) tick();
    reset = 1'b1;
    #1;
    check({tag, "_ready_first_cycle"}, int'(batch_ready), 0);
    tick();
    check({tag, "_ready_after"}, int'(batch_ready), 1);
  endtask

  task automatic run_test1(input string tag);
    logic [4*MPB-1:0] b;
    int s0;
    b = '0;
    b[3:0]   = 4'd2;
    b[7:4]   = 4'd5;
    b[11:8]  = 4'd13;
    b[19:16] = 4'd7;  // after the terminator, must be ignored
    s0 = n_starts;
    max_count       = 0;
    first_start_cyc = -1;
    send_batch(b);
    wait_idle({tag, "_idle"});
    check({tag, "_latency"}, first_start_cyc - accept_cyc, 3);
    check({tag, "_starts"}, n_starts - s0, 3);
    check({tag, "_peak_le3"}, (max_count <= 3) ? 1 : 0, 1);
    check({tag, "_count_end"}, int'(count), 0);
    check({tag, "_bad"}, int'(bad_code), int'(exp_bad));
  endtask

  initial begin
    logic [4*MPB-1:0] b;
    int s0, t, rc, dc;

    repeat (3) tick();
    reset_release("por");

    run_test1("t1");

    // Full alternating batch, driver latency 20, settle 8: starts every 30 cycles.
    b = '0;
    for (int k = 0; k < MPB; k++) b[4*k +: 4] = (k % 2 == 0) ? 4'd4 : 4'd5;
    s0 = n_starts;
    done_lat       = 20;
    exp_spacing    = 30;
    last_start_cyc = -1;
    check_spacing  = 1'b1;
    send_batch(b);
    rc = -1;
    t  = 0;
    while (!is_idle() && t < 3000) begin
      if (batch_ready && rc < 0) rc = int'(count);
      tick();
      t++;
    end
    wait_idle("t2_idle");
    check_spacing = 1'b0;
    check("t2_starts", n_starts - s0, MPB);
    check("t2_ready_count", rc, DEPTH - MPB);

    // Invalid codes between valid moves.
    b = '0;
    b[3:0]   = 4'd6;
    b[7:4]   = 4'd1;
    b[11:8]  = 4'd14;
    b[15:12] = 4'd15;
    b[19:16] = 4'd7;
    s0 = n_starts;
    send_batch(b);
    wait_idle("t3_idle");
    check("t3_starts", n_starts - s0, 2);
    check("t3_bad", int'(bad_code), 1);

    // Spurious move_done in I_IDLE and I_SETTLE.
    auto_done = 1'b0;
    move_done = 1'b1;
    tick();
    move_done = 1'b0;
    tick();
    check("sp_idle_busy", int'(busy), 0);
    check("sp_idle_count", int'(count), 0);
    b = '0;
    b[3:0] = 4'd9;
    s0 = n_starts;
    send_batch(b);
    wait_start(s0);
    repeat (3) tick();
    move_done = 1'b1;
    tick();
    move_done = 1'b0;
    dc = cyc;
    repeat (2) tick();
    move_done = 1'b1;
    tick();
    move_done = 1'b0;
    check("sp_settle_busy", int'(busy), 1);
    check("sp_settle_count", int'(count), 0);
    t = 0;
    while (busy && t < 100) begin
      tick();
      t++;
    end
    check("sp_settle_len", cyc - dc, SETTLE);
    check("sp_bad_sticky", int'(bad_code), 1);
    auto_done = 1'b1;
    wait_idle("sp_idle");

    // Flush with 10 moves queued while the current move is in I_WAIT.
    done_lat = 40;
    b = '0;
    for (int k = 0; k < 11; k++) b[4*k +: 4] = 4'($urandom_range(2, 13));
    s0 = n_starts;
    send_batch(b);
    wait_start(s0);
    repeat (12) tick();
    check("fl_count_before", int'(count), exp_q.size());
    check("fl_busy_before", int'(busy), 1);
    flush       = 1'b1;
    batch_valid = 1'b1;
    batch       = b;
    #1;
    check("fl_ready_blocked", int'(batch_ready), 0);
    tick();
    flush       = 1'b0;
    batch_valid = 1'b0;
    exp_q.delete();
    check("fl_count_after", int'(count), 0);
    check("fl_empty_after", int'(queue_empty), 1);
    check("fl_busy_after", int'(busy), 1);
    s0 = n_starts;
    t  = 0;
    while (busy && t < 200) begin
      tick();
      t++;
    end
    check("fl_move_finished", int'(busy), 0);
    repeat (20) tick();
    check("fl_no_more_starts", n_starts - s0, 0);
    done_lat = 20;

    // Randomized batches with random driver latency.
    rand_lat = 1'b1;
    for (int i = 0; i < 6; i++) begin
      b = '0;
      for (int k = 0; k < MPB; k++) begin
        int r;
        r = int'($urandom_range(0, 99));
        if (r < 2) b[4*k +: 4] = 4'd0;
        else if (r < 7) b[4*k +: 4] = (r == 2) ? 4'd1 : ((r < 5) ? 4'd14 : 4'd15);
        else b[4*k +: 4] = 4'($urandom_range(2, 13));
      end
      send_batch(b);
    end
    wait_idle("rnd_idle");
    check("rnd_bad", int'(bad_code), int'(exp_bad));
    rand_lat = 1'b0;

    // Reset in the middle of I_SETTLE.
    b = '0;
    b[3:0] = 4'd3;
    b[7:4] = 4'd4;
    s0 = n_starts;
    send_batch(b);
    wait_start(s0);
    repeat (24) tick();
    check("rs_busy_before", int'(busy), 1);
    #2;
    reset = 1'b0;
    exp_q.delete();
    exp_bad = 1'b0;
    reset_release("rs_settle");
    repeat (10) tick();

    // Reset during a move_start pulse while a full batch is still unpacking.
    for (int k = 0; k < MPB; k++) b[4*k +: 4] = 4'($urandom_range(2, 13));
    send_batch(b);
    t = 0;
    while (!move_start && t < 50) begin
      tick();
      t++;
    end
    #1;
    check("ru_start_before", int'(move_start), 1);
    reset = 1'b0;
    exp_q.delete();
    exp_bad = 1'b0;
    reset_release("rs_urun");
    repeat (30) tick();

    run_test1("t1b");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation still running at cycle %0d, required finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
